// File: rtl/vga_timing_gen_pkg.sv
// Shared timing defaults, widths and axis phase encoding for the VGA timing generator.
package vga_timing_gen_pkg;

   localparam int unsigned DEF_H_ACTIVE      = 640;
   localparam int unsigned DEF_H_FP          = 16;
   localparam int unsigned DEF_H_SYNC        = 96;
   localparam int unsigned DEF_H_BP          = 48;
   localparam int unsigned DEF_V_ACTIVE      = 480;
   localparam int unsigned DEF_V_FP          = 10;
   localparam int unsigned DEF_V_SYNC        = 2;
   localparam int unsigned DEF_V_BP          = 33;
   localparam int unsigned DEF_DATA_WIDTH    = 12;
   localparam int unsigned DEF_COUNTER_WIDTH = 10;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_t;

endpackage

// File: rtl/vga_axis_timer.sv
// One display axis: position counter, ACTIVE/FRONT/SYNC/BACK phase FSM and sync/active decode.
module vga_axis_timer
   import vga_timing_gen_pkg::*;
#(
   parameter int unsigned ACTIVE        = DEF_H_ACTIVE,
   parameter int unsigned FP            = DEF_H_FP,
   parameter int unsigned SYNC          = DEF_H_SYNC,
   parameter int unsigned BP            = DEF_H_BP,
   parameter int unsigned COUNTER_WIDTH = DEF_COUNTER_WIDTH
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   output logic [COUNTER_WIDTH-1:0] count,
   output logic                     wrap,
   output logic                     active,
   output logic                     sync
);

   localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
   localparam logic [COUNTER_WIDTH-1:0] END_ACTIVE = COUNTER_WIDTH'(ACTIVE - 1);
   localparam logic [COUNTER_WIDTH-1:0] END_FRONT  = COUNTER_WIDTH'(ACTIVE + FP - 1);
   localparam logic [COUNTER_WIDTH-1:0] END_SYNC   = COUNTER_WIDTH'(ACTIVE + FP + SYNC - 1);
   localparam logic [COUNTER_WIDTH-1:0] END_TOTAL  = COUNTER_WIDTH'(TOTAL - 1);

   phase_t                     phase, phase_nxt;
   logic [COUNTER_WIDTH-1:0]   count_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         phase <= PH_ACTIVE;
      end else begin
         count <= count_nxt;
         phase <= phase_nxt;
      end
   end

   // Phase tracks the counter: each transition fires on the last count of the current phase.
   always_comb begin
      count_nxt = count;
      phase_nxt = phase;
      wrap      = tick && (count == END_TOTAL);
      if (tick) begin
         count_nxt = (count == END_TOTAL) ? '0 : count + COUNTER_WIDTH'(1);
         case (phase)
            PH_ACTIVE: if (count == END_ACTIVE) phase_nxt = PH_FRONT;
            PH_FRONT:  if (count == END_FRONT)  phase_nxt = PH_SYNC;
            PH_SYNC:   if (count == END_SYNC)   phase_nxt = PH_BACK;
            PH_BACK:   if (count == END_TOTAL)  phase_nxt = PH_ACTIVE;
            default:   phase_nxt = PH_ACTIVE;
         endcase
      end
   end

   assign active = (phase == PH_ACTIVE);
   assign sync   = (phase == PH_SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: two axis timers plus registered sync/enable/colour outputs.
// Optional colour-bar test pattern with input Test_Mode when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int unsigned H_ACTIVE      = DEF_H_ACTIVE,
   parameter int unsigned H_FP          = DEF_H_FP,
   parameter int unsigned H_SYNC        = DEF_H_SYNC,
   parameter int unsigned H_BP          = DEF_H_BP,
   parameter int unsigned V_ACTIVE      = DEF_V_ACTIVE,
   parameter int unsigned V_FP          = DEF_V_FP,
   parameter int unsigned V_SYNC        = DEF_V_SYNC,
   parameter int unsigned V_BP          = DEF_V_BP,
   parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int unsigned COUNTER_WIDTH = DEF_COUNTER_WIDTH
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     Pix_En,
   input  logic [DATA_WIDTH-1:0]    Data_VGA,
`ifdef VGA_TEST_PATTERN_EN
   input  logic                     Test_Mode,
`endif
   output logic [COUNTER_WIDTH-1:0] Pixel_X,
   output logic [COUNTER_WIDTH-1:0] Pixel_Y,
   output logic                     HSync,
   output logic                     VSync,
   output logic                     Display_Enable,
   output logic [DATA_WIDTH-1:0]    RGB,
   output logic                     Frame_Start
);

   logic [COUNTER_WIDTH-1:0] h_count, v_count;
   logic                     h_wrap, v_wrap, h_active, v_active, h_sync, v_sync;
   logic                     visible;
   logic [DATA_WIDTH-1:0]    pix_src;

   vga_axis_timer #(
      .ACTIVE        (H_ACTIVE),
      .FP            (H_FP),
      .SYNC          (H_SYNC),
      .BP            (H_BP),
      .COUNTER_WIDTH (COUNTER_WIDTH)
   ) u_h_timer (
      .clk    (clk),
      .rst    (rst),
      .tick   (Pix_En),
      .count  (h_count),
      .wrap   (h_wrap),
      .active (h_active),
      .sync   (h_sync)
   );

   // The vertical axis advances only on the pixel tick that ends a line.
   vga_axis_timer #(
      .ACTIVE        (V_ACTIVE),
      .FP            (V_FP),
      .SYNC          (V_SYNC),
      .BP            (V_BP),
      .COUNTER_WIDTH (COUNTER_WIDTH)
   ) u_v_timer (
      .clk    (clk),
      .rst    (rst),
      .tick   (h_wrap),
      .count  (v_count),
      .wrap   (v_wrap),
      .active (v_active),
      .sync   (v_sync)
   );

   assign Pixel_X = h_count;
   assign Pixel_Y = v_count;
   assign visible = h_active && v_active;

`ifdef VGA_TEST_PATTERN_EN
   localparam int unsigned BAR_W = H_ACTIVE / 8;
   localparam int unsigned CH_W  = DATA_WIDTH / 3;

   logic [2:0] bar_sel;

   always_comb begin
      bar_sel = 3'(h_count / COUNTER_WIDTH'(BAR_W));
      pix_src = Data_VGA;
      if (Test_Mode)
         pix_src = DATA_WIDTH'({{CH_W{bar_sel[2]}}, {CH_W{bar_sel[1]}}, {CH_W{bar_sel[0]}}});
   end
`else
   assign pix_src = Data_VGA;
`endif

   // Frame_Start is the only output not gated by Pix_En so the pulse is one clk wide.
   always_ff @(posedge clk) begin
      if (rst) begin
         HSync          <= 1'b1;
         VSync          <= 1'b1;
         Display_Enable <= 1'b0;
         RGB            <= '0;
         Frame_Start    <= 1'b0;
      end else begin
         Frame_Start <= v_wrap;
         if (Pix_En) begin
            HSync          <= ~h_sync;
            VSync          <= ~v_sync;
            Display_Enable <= visible;
            RGB            <= visible ? pix_src : '0;
         end
      end
   end

endmodule
